// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port for imem_loader.
// master = image source / memory side, slave = the loader itself.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int WIDTH      = 32
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]      mem_wdata;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader: header byte N, then 4N little-endian bytes -> N word writes.
// Optional trailer XOR checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
   parameter int ADDR_WIDTH = 3,
   parameter int WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   imem_loader_if.slave          bus,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   n_q, n_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [WIDTH-1:0]      asm_q, asm_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif

   logic in_ready;
   logic accept;
   logic hdr_bad;

   always_comb begin
      in_ready = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                 || (state_q == S_CSUM)
`endif
                 ;
   end

   assign accept  = bus.in_valid && in_ready;
   assign hdr_bad = (bus.in_data == 8'd0) || (int'(bus.in_data) > DEPTH);

   // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      words_d    = words_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_HDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = 8'd0;
`endif
            end
         end

         S_HDR: begin
            if (accept) begin
               if (hdr_bad) begin
                  state_d = S_ERR;
               end else begin
                  n_d        = (ADDR_WIDTH + 1)'(bus.in_data);
                  words_d    = '0;
                  byte_cnt_d = 2'd0;
                  state_d    = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ bus.in_data;
`endif
               // Latch the write address and word now so they are stable for the whole WRITE cycle.
               if (byte_cnt_q == 2'd3) begin
                  addr_d  = words_q[ADDR_WIDTH-1:0];
                  wdata_d = asm_d;
                  state_d = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            words_d = words_q + 1'b1;
            if (words_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_DATA;
            end
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: only the loader's own registers reset; the instruction memory image is left intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         words_q    <= '0;
         byte_cnt_q <= 2'd0;
         asm_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         words_q    <= words_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.mem_we    = (state_q == S_WRITE);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign cpu_hold      = (state_q != S_DONE);
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERR);
   assign words_loaded  = words_q;

endmodule
